// File: rtl/taglist_pkg.sv
// Shared definitions for the tag-list generator.
//   - ROM end-flag encodings
//   - scan FSM state type
//   - entry field offsets as functions of the ROM address width
//   - pack_entry(): builds a tag entry in a wide word; callers truncate to their RAM width
package taglist_pkg;

   // 2'b00 / 2'b01 both mean "word belongs to the current sequence"
   localparam logic [1:0] FLAG_END_SEQ = 2'b10;
   localparam logic [1:0] FLAG_END_ROM = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StEval,
      StWrite,
      StDone
   } state_e;

   // Working width for pack_entry; any legal DATA_W up to this is supported.
   localparam int unsigned ENTRY_MAX_W = 256;

   localparam int unsigned FINAL_LSB = 0;
   localparam int unsigned LAST_LSB  = 1;

   function automatic int unsigned first_lsb(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

   function automatic int unsigned seq_lsb(input int unsigned addr_w);
      return 2 * addr_w + 1;
   endfunction

   // Fields must arrive zero-extended so nothing spills into a neighbour.
   function automatic logic [ENTRY_MAX_W-1:0] pack_entry(
      input int unsigned            addr_w,
      input logic [ENTRY_MAX_W-1:0] seq,
      input logic [ENTRY_MAX_W-1:0] first,
      input logic [ENTRY_MAX_W-1:0] last,
      input logic                   fin
   );
      logic [ENTRY_MAX_W-1:0] word;
      word = (seq << seq_lsb(addr_w)) | (first << first_lsb(addr_w)) | (last << LAST_LSB);
      word[FINAL_LSB] = fin;
      return word;
   endfunction

endpackage

// File: rtl/taglist_entry_pack.sv
// Combinational tag-entry packer.
//   i_seq   : sequence number
//   i_first : first ROM address of the sequence
//   i_last  : last ROM address of the sequence
//   i_final : set on the last entry of a scan
//   o_data  : packed entry, bits above the fields are zero
module taglist_entry_pack
   import taglist_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned SEQ_W  = 7,
   parameter int unsigned DATA_W = 32
) (
   input  logic [SEQ_W-1:0]  i_seq,
   input  logic [ADDR_W-1:0] i_first,
   input  logic [ADDR_W-1:0] i_last,
   input  logic              i_final,
   output logic [DATA_W-1:0] o_data
);

   assign o_data = DATA_W'(pack_entry(ADDR_W,
                                      ENTRY_MAX_W'(i_seq),
                                      ENTRY_MAX_W'(i_first),
                                      ENTRY_MAX_W'(i_last),
                                      i_final));

endmodule

// File: rtl/taglist_gen_param.sv
// Tag-list generator. On start, walks a synchronous sequence ROM one word per two cycles,
// and writes one entry per sequence {seq, first, last, final} into tag RAM over a
// valid/ready handshake.
//   clk_1KHz, reset      : clock, asynchronous active-high reset
//   start                : scan request, honoured only in idle/done
//   rom_addr / rom_flag  : ROM read port, flag valid one cycle after address
//   ram_we / ram_ready   : write valid / accept
//   ram_addr / ram_data  : entry index and packed entry, stable while ram_we is high
//   busy, done           : scan in progress / scan finished (held until next start)
//   entry_count          : entries committed in this scan
//   err_wrap, err_ovf    : ROM ended without end-of-ROM flag / too many sequences
module taglist_gen_param
   import taglist_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned SEQ_W  = 7,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_1KHz,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [1:0]        rom_flag,
   output logic              ram_we,
   input  logic              ram_ready,
   output logic [SEQ_W-1:0]  ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              busy,
   output logic              done,
   output logic [SEQ_W:0]    entry_count,
   output logic              err_wrap,
   output logic              err_ovf
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [SEQ_W-1:0]  SEQ_MAX  = '1;

   state_e              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_first;
   logic [SEQ_W-1:0]    r_seq;
   logic [DATA_W-1:0]   r_entry;
   logic                r_ram_we;
   logic                r_busy;
   logic                r_done;
   logic                r_err_wrap;
   logic                r_err_ovf;
   logic [SEQ_W:0]      r_count;

   logic                w_addr_max;
   logic                w_seq_max;
   logic                w_end_seq;
   logic                w_eval_final;
   logic [DATA_W-1:0]   w_entry;

   assign w_addr_max = (r_addr == ADDR_MAX);
   assign w_seq_max  = (r_seq == SEQ_MAX);
   assign w_end_seq  = rom_flag[1];
   // Final entry: explicit end-of-ROM, or running off the last address mid-sequence.
   assign w_eval_final = (rom_flag == FLAG_END_ROM) || (!w_end_seq && w_addr_max);

   taglist_entry_pack #(
      .ADDR_W (ADDR_W),
      .SEQ_W  (SEQ_W),
      .DATA_W (DATA_W)
   ) u_pack (
      .i_seq   (r_seq),
      .i_first (r_first),
      .i_last  (r_addr),
      .i_final (w_eval_final),
      .o_data  (w_entry)
   );

   always_ff @(posedge clk_1KHz or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_first    <= '0;
         r_seq      <= '0;
         r_entry    <= '0;
         r_ram_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err_wrap <= 1'b0;
         r_err_ovf  <= 1'b0;
         r_count    <= '0;
      end else begin
         case (r_state)
            StIdle, StDone: begin
               if (start) begin
                  r_addr     <= '0;
                  r_first    <= '0;
                  r_seq      <= '0;
                  r_count    <= '0;
                  r_done     <= 1'b0;
                  r_err_wrap <= 1'b0;
                  r_err_ovf  <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= StAddr;
               end
            end
            StAddr: begin
               // ROM latches rom_addr on this edge; flag is valid during StEval.
               r_state <= StEval;
            end
            StEval: begin
               if (w_end_seq || w_addr_max) begin
                  if (!w_end_seq) begin
                     r_err_wrap <= 1'b1;
                  end
                  r_entry  <= w_entry;
                  r_ram_we <= 1'b1;
                  r_state  <= StWrite;
               end else begin
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_state <= StAddr;
               end
            end
            StWrite: begin
               if (ram_ready) begin
                  r_ram_we <= 1'b0;
                  r_count  <= r_count + (SEQ_W + 1)'(1);
                  if (r_entry[FINAL_LSB]) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= StDone;
                  end else if (w_seq_max) begin
                     r_err_ovf <= 1'b1;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= StDone;
                  end else if (w_addr_max) begin
                     r_err_wrap <= 1'b1;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= StDone;
                  end else begin
                     r_seq   <= r_seq + SEQ_W'(1);
                     r_first <= r_addr + ADDR_W'(1);
                     r_addr  <= r_addr + ADDR_W'(1);
                     r_state <= StAddr;
                  end
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign rom_addr    = r_addr;
   assign ram_we      = r_ram_we;
   assign ram_addr    = r_seq;
   assign ram_data    = r_entry;
   assign busy        = r_busy;
   assign done        = r_done;
   assign entry_count = r_count;
   assign err_wrap    = r_err_wrap;
   assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_taglist_gen_param.sv
// Directed bench: instance A (ADDR_W=4, SEQ_W=3) and instance B (ADDR_W=4, SEQ_W=2),
// each with a small ROM model and a write monitor. Entry words are hand-computed.
module tb_taglist_gen_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Instance A
   logic        a_start, a_ram_ready, a_ram_we, a_busy, a_done, a_wrap, a_ovf;
   logic [3:0]  a_rom_addr, a_count;
   logic [1:0]  a_rom_flag;
   logic [2:0]  a_ram_addr;
   logic [15:0] a_ram_data;
   logic [1:0]  a_rom [16];
   logic [15:0] a_q_data [$];
   logic [2:0]  a_q_addr [$];

   // Instance B
   logic        b_start, b_ram_ready, b_ram_we, b_busy, b_done, b_wrap, b_ovf;
   logic [3:0]  b_rom_addr;
   logic [2:0]  b_count;
   logic [1:0]  b_rom_flag;
   logic [1:0]  b_ram_addr;
   logic [15:0] b_ram_data;
   logic [1:0]  b_rom [16];
   logic [15:0] b_q_data [$];
   logic [1:0]  b_q_addr [$];

   taglist_gen_param #(.ADDR_W(4), .SEQ_W(3), .DATA_W(16)) dut_a (
      .clk_1KHz (clk), .reset (rst), .start (a_start),
      .rom_addr (a_rom_addr), .rom_flag (a_rom_flag),
      .ram_we (a_ram_we), .ram_ready (a_ram_ready),
      .ram_addr (a_ram_addr), .ram_data (a_ram_data),
      .busy (a_busy), .done (a_done), .entry_count (a_count),
      .err_wrap (a_wrap), .err_ovf (a_ovf)
   );

   taglist_gen_param #(.ADDR_W(4), .SEQ_W(2), .DATA_W(16)) dut_b (
      .clk_1KHz (clk), .reset (rst), .start (b_start),
      .rom_addr (b_rom_addr), .rom_flag (b_rom_flag),
      .ram_we (b_ram_we), .ram_ready (b_ram_ready),
      .ram_addr (b_ram_addr), .ram_data (b_ram_data),
      .busy (b_busy), .done (b_done), .entry_count (b_count),
      .err_wrap (b_wrap), .err_ovf (b_ovf)
   );

   // Synchronous ROMs and committed-write monitors
   always @(posedge clk) begin
      a_rom_flag <= a_rom[a_rom_addr];
      b_rom_flag <= b_rom[b_rom_addr];
      if (a_ram_we && a_ram_ready) begin
         a_q_data.push_back(a_ram_data);
         a_q_addr.push_back(a_ram_addr);
      end
      if (b_ram_we && b_ram_ready) begin
         b_q_data.push_back(b_ram_data);
         b_q_addr.push_back(b_ram_addr);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] a_data_at(input int i);
      return (i < a_q_data.size()) ? a_q_data[i] : 16'hDEAD;
   endfunction

   function automatic logic [2:0] a_addr_at(input int i);
      return (i < a_q_addr.size()) ? a_q_addr[i] : 3'h7;
   endfunction

   task automatic pulse_a();
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
   endtask

   task automatic load_rom_test1();
      for (int i = 0; i < 16; i++) a_rom[i] = 2'b00;
      a_rom[2] = 2'b10;
      a_rom[4] = 2'b11;
   endtask

   // Waits for done; stalls each write by 'stall' cycles and checks it holds steady.
   task automatic wait_done_a(input int stall);
      int          stall_cnt;
      logic [15:0] held_data;
      logic [2:0]  held_addr;
      stall_cnt = 0;
      held_data = '0;
      held_addr = '0;
      a_ram_ready = (stall == 0);
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (a_done) break;
         if (a_ram_we) begin
            if (stall_cnt == 0) begin
               held_data = a_ram_data;
               held_addr = a_ram_addr;
            end else begin
               check_eq("stall_data", a_ram_data, held_data);
               check_eq("stall_addr", a_ram_addr, held_addr);
            end
            if (stall_cnt == stall) begin
               if (stall > 0) check_eq("done_before_hs", a_done, 1'b0);
               a_ram_ready = 1'b1;
               stall_cnt   = 0;
            end else begin
               a_ram_ready = 1'b0;
               stall_cnt++;
            end
         end else begin
            a_ram_ready = (stall == 0);
         end
      end
      check_eq("a_done", a_done, 1'b1);
      a_ram_ready = 1'b1;
   endtask

   task automatic check_test1_entries(input string tag);
      check_eq({tag, "_n"}, a_q_data.size(), 2);
      check_eq({tag, "_d0"}, a_data_at(0), 16'h0004);
      check_eq({tag, "_a0"}, a_addr_at(0), 3'd0);
      check_eq({tag, "_d1"}, a_data_at(1), 16'h0269);
      check_eq({tag, "_a1"}, a_addr_at(1), 3'd1);
      check_eq({tag, "_cnt"}, a_count, 4'd2);
      check_eq({tag, "_wrap"}, a_wrap, 1'b0);
      check_eq({tag, "_ovf"}, a_ovf, 1'b0);
      check_eq({tag, "_busy"}, a_busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      a_ram_ready = 1'b1;
      b_ram_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a_rom[i] = 2'b00;
         b_rom[i] = 2'b10;
      end
      repeat (2) @(negedge clk);

      // Reset state
      check_eq("rst_busy", a_busy, 1'b0);
      check_eq("rst_done", a_done, 1'b0);
      check_eq("rst_we", a_ram_we, 1'b0);
      check_eq("rst_rom_addr", a_rom_addr, 4'd0);
      check_eq("rst_cnt", a_count, 4'd0);
      check_eq("rst_data", a_ram_data, 16'h0);
      rst = 1'b0;

      // Two sequences, plus start pulses while busy that must be ignored
      load_rom_test1();
      pulse_a();
      check_eq("t1_busy", a_busy, 1'b1);
      pulse_a();
      wait_done_a(0);
      check_test1_entries("t1");

      // Restart from DONE
      a_q_data.delete();
      a_q_addr.delete();
      pulse_a();
      check_eq("t6_done_clr", a_done, 1'b0);
      check_eq("t6_rom_addr", a_rom_addr, 4'd0);
      check_eq("t6_busy", a_busy, 1'b1);
      check_eq("t6_cnt", a_count, 4'd0);
      wait_done_a(0);
      check_test1_entries("t6");

      // Same ROM with 5-cycle write stalls
      a_q_data.delete();
      a_q_addr.delete();
      pulse_a();
      wait_done_a(5);
      check_test1_entries("t2");

      // No end-of-ROM flag anywhere: wrap
      for (int i = 0; i < 16; i++) a_rom[i] = 2'b00;
      a_q_data.delete();
      a_q_addr.delete();
      pulse_a();
      wait_done_a(0);
      check_eq("t3_n", a_q_data.size(), 1);
      check_eq("t3_d0", a_data_at(0), 16'h001F);
      check_eq("t3_wrap", a_wrap, 1'b1);
      check_eq("t3_ovf", a_ovf, 1'b0);
      check_eq("t3_cnt", a_count, 4'd1);

      // Reset while a write is pending
      load_rom_test1();
      a_q_data.delete();
      a_q_addr.delete();
      a_ram_ready = 1'b0;
      pulse_a();
      for (int cyc = 0; cyc < 50; cyc++) begin
         if (a_ram_we) break;
         @(negedge clk);
      end
      check_eq("t5_we_pre", a_ram_we, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("t5_we", a_ram_we, 1'b0);
      check_eq("t5_busy", a_busy, 1'b0);
      check_eq("t5_data", a_ram_data, 16'h0);
      check_eq("t5_rom_addr", a_rom_addr, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      a_ram_ready = 1'b1;
      check_eq("t5_no_commit", a_q_data.size(), 0);
      pulse_a();
      check_eq("t5_rescan_addr", a_rom_addr, 4'd0);
      check_eq("t5_rescan_cnt", a_count, 4'd0);
      wait_done_a(0);
      check_test1_entries("t5");

      // Instance B: every word ends a sequence, entries overflow after 4
      @(negedge clk) b_start = 1'b1;
      @(negedge clk) b_start = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (b_done) break;
         @(negedge clk);
      end
      check_eq("t4_done", b_done, 1'b1);
      check_eq("t4_n", b_q_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         logic [15:0] exp_d [4];
         exp_d[0] = 16'h0000;
         exp_d[1] = 16'h0222;
         exp_d[2] = 16'h0444;
         exp_d[3] = 16'h0666;
         check_eq("t4_data", (i < b_q_data.size()) ? b_q_data[i] : 16'hDEAD, exp_d[i]);
         check_eq("t4_addr", (i < b_q_addr.size()) ? b_q_addr[i] : 2'bxx, i[1:0]);
      end
      check_eq("t4_ovf", b_ovf, 1'b1);
      check_eq("t4_wrap", b_wrap, 1'b0);
      check_eq("t4_cnt", b_count, 3'd4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
